// File: rtl/cpu_pkg.sv
// Shared RV32I core types and constants.
// Fetch FSM encoding, NOP encoding and the default reset PC.
package cpu_pkg;

   typedef enum logic {
      F_IDLE,
      F_WAIT
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset value, word-aligned target load, +4 increment.
// Single-cycle update; load wins over increment; no backpressure of its own.
module pc_reg
   import cpu_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] target_i,
   input  logic                  inc_i,
   output logic [ADDR_WIDTH-1:0] pc_o
);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;

   // Low two target bits are dropped so fetches always stay word aligned.
   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = target_i & ~ADDR_WIDTH'(3);
      end else if (inc_i) begin
         pc_d = pc_q + ADDR_WIDTH'(4);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one imem read outstanding, response lands in a one-entry slot one cycle later.
// Decode stall holds the slot and blocks new requests; redirects flush the slot and kill stale fetches.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] target_i,
   output logic                  imem_req_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_rvalid_i,
   input  logic [31:0]           imem_rdata_i,
   output logic                  valid_o,
   output logic [31:0]           instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic [ADDR_WIDTH-1:0] pc_plus4_o,
   output logic                  misalign_o
);

   fetch_state_t          state_q, state_d;
   logic                  kill_q, kill_d;
   logic                  valid_q, valid_d;
   logic                  misalign_q, misalign_d;
   logic [31:0]           instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic                  pc_load;
   logic                  pc_inc;
   logic                  req;

   pc_reg #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_pc_reg (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load_i   (pc_load),
      .target_i (target_i),
      .inc_i    (pc_inc),
      .pc_o     (fetch_pc)
   );

   always_comb begin
      state_d    = state_q;
      kill_d     = kill_q;
      valid_d    = valid_q & stall_i;
      instr_d    = instr_q;
      pc_out_d   = pc_out_q;
      misalign_d = misalign_q | (redirect_i & (target_i[1:0] != 2'b00));
      pc_load    = 1'b0;
      pc_inc     = 1'b0;
      req        = 1'b0;

      if (redirect_i) begin
         pc_load = 1'b1;
         valid_d = 1'b0;
         // A response arriving with the redirect is dropped outright; otherwise it is marked stale.
         if (state_q == F_WAIT) begin
            if (imem_rvalid_i) begin
               state_d = F_IDLE;
               kill_d  = 1'b0;
            end else begin
               kill_d  = 1'b1;
            end
         end
      end else begin
         unique case (state_q)
            F_IDLE: begin
               if (!valid_q || !stall_i) begin
                  req     = 1'b1;
                  state_d = F_WAIT;
               end
            end
            F_WAIT: begin
               if (imem_rvalid_i) begin
                  state_d = F_IDLE;
                  if (kill_q) begin
                     kill_d = 1'b0;
                  end else begin
                     valid_d  = 1'b1;
                     instr_d  = imem_rdata_i;
                     pc_out_d = fetch_pc;
                     pc_inc   = 1'b1;
                  end
               end
            end
            default: state_d = F_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= F_IDLE;
         kill_q     <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= NOP_INSTR;
         pc_out_q   <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         kill_q     <= kill_d;
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_out_q   <= pc_out_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_req_o  = req & ~rst_i;
   assign imem_addr_o = fetch_pc;
   assign valid_o     = valid_q;
   assign instr_o     = instr_q;
   assign pc_o        = pc_out_q;
   assign pc_plus4_o  = pc_out_q + ADDR_WIDTH'(4);
   assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through the fetch/stall/redirect/reset scenarios, then random traffic.
// Expected instruction stream is a sequential PC walk restarted on every redirect or reset.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   localparam int FD_VLD   = 0;
   localparam int FD_INSTR = 1;
   localparam int FD_PC    = 2;
   localparam int FD_REQ   = 3;
   localparam int FD_ADDR  = 4;
   localparam int FD_MIS   = 5;
   localparam int FD_PC4   = 6;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] target_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus4_o;
   logic        misalign_o;

   fetch_stage #(
      .ADDR_WIDTH (32),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .target_i      (target_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .valid_o       (valid_o),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o),
      .misalign_o    (misalign_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       name;
      int          fld;
      logic [31:0] val;
   } dexp_t;

   int          checks   = 0;
   int          errors   = 0;
   int          consumed = 0;
   int          idle_run = 0;
   bit          mis_m    = 1'b0;
   bit          outstanding = 1'b0;
   bit          final_chk = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_tail;
   dexp_t       dq[$];
   logic [31:0] req_q[$];

   // Memory responder state, owned by the stimulus process.
   bit          mem_pend = 1'b0;
   int          mem_wait = 0;
   logic [31:0] mem_addr = 32'h0;
   int          k_cfg    = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void restart(input logic [31:0] pc);
      exp_q.delete();
      for (int i = 0; i < 4; i++) exp_q.push_back(pc + 32'(4 * i));
      exp_tail = pc + 32'd12;
   endfunction

   // Monitor: samples on the falling edge, judging what the next rising edge will do.
   always @(negedge clk_i) begin : mon
      dexp_t       d;
      logic [31:0] act;
      logic [31:0] e;
      while (dq.size() > 0) begin
         d = dq.pop_front();
         case (d.fld)
            FD_VLD:   act = 32'(valid_o);
            FD_INSTR: act = instr_o;
            FD_PC:    act = pc_o;
            FD_REQ:   act = 32'(imem_req_o);
            FD_ADDR:  act = imem_addr_o;
            FD_MIS:   act = 32'(misalign_o);
            FD_PC4:   act = pc_plus4_o;
            default:  act = 'x;
         endcase
         chk(d.name, act, d.val);
      end
      if (rst_i) begin
         restart(RST_PC);
         mis_m       = 1'b0;
         outstanding = 1'b0;
         idle_run    = 0;
      end else begin
         chk("misalign_sticky", 32'(misalign_o), 32'(mis_m));
         if (imem_rvalid_i) outstanding = 1'b0;
         if (imem_req_o) begin
            chk("req_while_outstanding", 32'(outstanding), 32'd0);
            outstanding = 1'b1;
            req_q.push_back(imem_addr_o);
         end
         if (valid_o && !stall_i) begin
            consumed++;
            e = exp_q.pop_front();
            chk("stream_pc", pc_o, e);
            chk("stream_instr", instr_o, e + 32'h100);
            chk("stream_pc_plus4", pc_plus4_o, e + 32'd4);
            exp_tail = exp_tail + 32'd4;
            exp_q.push_back(exp_tail);
         end
         if (valid_o) begin
            idle_run = 0;
         end else begin
            idle_run++;
            if (idle_run == 200) begin
               checks++;
               errors++;
               $display("FAIL liveness: %0d cycles without valid_o, limit 199", idle_run);
            end
         end
         if (redirect_i) begin
            restart({target_i[31:2], 2'b00});
            if (target_i[1:0] != 2'b00) mis_m = 1'b1;
         end
      end
      if (final_chk) chk("consumed_at_least_100", 32'(consumed >= 100), 32'd1);
   end

   task automatic expect_at(input string name, input int fld, input logic [31:0] val);
      dexp_t d;
      d.name = name;
      d.fld  = fld;
      d.val  = val;
      dq.push_back(d);
   endtask

   // Advance one cycle and drive the memory response for the new cycle.
   task automatic tick();
      @(posedge clk_i);
      #1;
      imem_rvalid_i = 1'b0;
      if (rst_i) mem_pend = 1'b0;
      if (!mem_pend && req_q.size() > 0) begin
         mem_addr = req_q.pop_front();
         mem_pend = 1'b1;
         mem_wait = k_cfg;
      end
      if (mem_pend) begin
         mem_wait--;
         if (mem_wait == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_addr + 32'h100;
            mem_pend      = 1'b0;
         end
      end
   endtask

   initial begin
      rst_i         = 1'b1;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      target_i      = 32'h0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      k_cfg         = 1;

      tick();
      tick();
      expect_at("rst_valid", FD_VLD, 32'd0);
      expect_at("rst_instr", FD_INSTR, NOP);
      expect_at("rst_pc", FD_PC, RST_PC);
      expect_at("rst_pc_plus4", FD_PC4, RST_PC + 32'd4);
      expect_at("rst_req", FD_REQ, 32'd0);
      expect_at("rst_addr", FD_ADDR, RST_PC);
      expect_at("rst_misalign", FD_MIS, 32'd0);
      tick();
      rst_i = 1'b0;                                   // cycle c0
      expect_at("first_req", FD_REQ, 32'd1);
      expect_at("first_addr", FD_ADDR, 32'h0);
      tick();
      tick();                                         // c0+2
      expect_at("second_req", FD_REQ, 32'd1);
      expect_at("second_addr", FD_ADDR, 32'h4);
      expect_at("first_out_pc", FD_PC, 32'h0);
      expect_at("first_out_instr", FD_INSTR, 32'h100);
      tick();
      tick();                                         // c0+4
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         expect_at("stall_valid", FD_VLD, 32'd1);
         expect_at("stall_pc", FD_PC, 32'h4);
         expect_at("stall_instr", FD_INSTR, 32'h104);
         expect_at("stall_no_req", FD_REQ, 32'd0);
         if (i < 2) tick();
      end
      tick();                                         // c0+7
      stall_i = 1'b0;
      k_cfg   = 3;
      expect_at("post_stall_req", FD_REQ, 32'd1);
      expect_at("post_stall_addr", FD_ADDR, 32'h8);
      tick();                                         // c0+8
      redirect_i = 1'b1;
      target_i   = 32'h40;
      expect_at("redir_wait_valid", FD_VLD, 32'd0);
      tick();
      redirect_i = 1'b0;
      expect_at("kill_valid", FD_VLD, 32'd0);
      tick();                                         // c0+10: stale response
      expect_at("kill_drop_valid", FD_VLD, 32'd0);
      expect_at("kill_no_req", FD_REQ, 32'd0);
      tick();                                         // c0+11
      expect_at("redir_req", FD_REQ, 32'd1);
      expect_at("redir_addr", FD_ADDR, 32'h40);
      expect_at("redir_valid", FD_VLD, 32'd0);
      repeat (4) tick();                              // c0+15
      expect_at("target_valid", FD_VLD, 32'd1);
      expect_at("target_pc", FD_PC, 32'h40);
      expect_at("target_instr", FD_INSTR, 32'h140);
      expect_at("target_next_addr", FD_ADDR, 32'h44);
      repeat (3) tick();                              // c0+18: response for 0x44
      redirect_i = 1'b1;
      target_i   = 32'h80;
      tick();                                         // c0+19
      redirect_i = 1'b0;
      k_cfg      = 1;
      expect_at("same_cycle_req", FD_REQ, 32'd1);
      expect_at("same_cycle_addr", FD_ADDR, 32'h80);
      expect_at("same_cycle_valid", FD_VLD, 32'd0);
      repeat (3) tick();                              // c0+22: response for 0x84
      redirect_i = 1'b1;
      target_i   = 32'h42;
      tick();                                         // c0+23
      redirect_i = 1'b0;
      k_cfg      = 3;
      expect_at("mis_req", FD_REQ, 32'd1);
      expect_at("mis_addr", FD_ADDR, 32'h40);
      expect_at("mis_flag", FD_MIS, 32'd1);
      tick();                                         // c0+24: reset during WAIT
      rst_i = 1'b1;
      tick();                                         // c0+25
      rst_i         = 1'b0;
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
      expect_at("post_rst_valid", FD_VLD, 32'd0);
      expect_at("post_rst_instr", FD_INSTR, NOP);
      expect_at("post_rst_pc", FD_PC, RST_PC);
      expect_at("post_rst_mis", FD_MIS, 32'd0);
      expect_at("post_rst_req", FD_REQ, 32'd1);
      expect_at("post_rst_addr", FD_ADDR, RST_PC);
      tick();
      expect_at("stray_ignored_valid", FD_VLD, 32'd0);
      expect_at("stray_ignored_instr", FD_INSTR, NOP);

      for (int n = 0; n < 3000; n++) begin
         tick();
         k_cfg      = int'($urandom_range(1, 4));
         rst_i      = ($urandom_range(0, 399) == 0);
         stall_i    = ($urandom_range(0, 9) < 3);
         redirect_i = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 2))
            0:       target_i = 32'($urandom_range(0, 255));
            1:       target_i = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: target_i = 32'($urandom_range(0, 1023)) << 2;
         endcase
      end
      tick();
      rst_i      = 1'b0;
      stall_i    = 1'b0;
      redirect_i = 1'b0;
      repeat (20) tick();
      final_chk = 1'b1;
      tick();
      final_chk = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
